// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two sequencer requesters, the shared word memory and mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          err0;
  logic          err1;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, err0, err1,
           mem_wr_en, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, err0, err1,
           mem_wr_en, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting two requesters share one single-port word memory.
// Optional build macro MEM_ARB_ALIGN_CHECK_EN rejects non-word-aligned requests with an err pulse.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          mem_wr_en_q, mem_wr_en_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          misaligned;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
`endif

  // On a tie the requester not granted last wins; a lone requester always wins.
  always_comb begin
    win       = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
    win_we    = win ? bus.we1    : bus.we0;
    win_addr  = win ? bus.addr1  : bus.addr0;
    win_wdata = win ? bus.wdata1 : bus.wdata0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    misaligned = (win_addr[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    err0_d      = 1'b0;
    err1_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          last_d  = win;
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          // A rejected request is granted and flagged but never touches the memory port.
          if (misaligned) begin
`ifdef MEM_ARB_ALIGN_CHECK_EN
            err0_d = ~win;
            err1_d = win;
`endif
          end else begin
            mem_addr_d  = win_addr;
            mem_wdata_d = win_wdata;
            mem_wr_en_d = win_we;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = mem_wr_en_q ? IDLE : WAIT;
      end
      WAIT: begin
        rdata_d   = bus.mem_rdata;
        rvalid0_d = ~owner_q;
        rvalid1_d = owner_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      err0_q <= err0_d;
      err1_q <= err1_d;
    end
  end

  assign bus.err0 = err0_q;
  assign bus.err1 = err1_q;
`else
  assign bus.err0 = 1'b0;
  assign bus.err1 = 1'b0;
`endif

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed requester traffic, a small word memory, and a
// transaction-level timeline model that predicts every output on every cycle.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory behind the arbiter: write on wr_en, read data one cycle after the address.
  logic [31:0] ram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    bus.mem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (bus.mem_wr_en) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[9:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: each accepted request schedules its output pulses at absolute cycle numbers.
  int          cyc = 0;
  int          busy_last, gnt_at, gnt_who, err_at, wr_at, rv_at, rv_who;
  logic [31:0] rv_data, e_addr, e_wdata, e_rdata;
  int          last_win;
  logic [31:0] mmem [0:255];

  function automatic void modelClear();
    busy_last = -100;
    gnt_at = -1; gnt_who = 0; err_at = -1; wr_at = -1; rv_at = -1; rv_who = 0;
    rv_data = 0; e_addr = 0; e_wdata = 0; e_rdata = 0;
    last_win = 1;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = 32'h0;
    modelClear();
  end

  always @(posedge rst) modelClear();

  always @(posedge clk) begin
    int          w;
    logic        wwe;
    logic [31:0] wa, wd;
    cyc++;
    if (rst) begin
      modelClear();
    end else begin
      if (rv_at == cyc) e_rdata = rv_data;
      if ((cyc - 1 > busy_last) && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) w = 1 - last_win;
        else                      w = bus.req1 ? 1 : 0;
        wwe = (w == 1) ? bus.we1    : bus.we0;
        wa  = (w == 1) ? bus.addr1  : bus.addr0;
        wd  = (w == 1) ? bus.wdata1 : bus.wdata0;
        last_win = w;
        gnt_at = cyc; gnt_who = w;
        if (ALIGN_EN && (wa % 4 != 0)) begin
          err_at = cyc;
        end else begin
          e_addr  = wa;
          e_wdata = wd;
          if (wwe) begin
            wr_at = cyc;
            mmem[wa[9:2]] = wd;
            busy_last = cyc;
          end else begin
            busy_last = cyc + 1;
            rv_at = cyc + 2; rv_who = w; rv_data = mmem[wa[9:2]];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("gnt0",      bus.gnt0,      (gnt_at == cyc && gnt_who == 0));
      checkOutput("gnt1",      bus.gnt1,      (gnt_at == cyc && gnt_who == 1));
      checkOutput("err0",      bus.err0,      (err_at == cyc && gnt_who == 0));
      checkOutput("err1",      bus.err1,      (err_at == cyc && gnt_who == 1));
      checkOutput("rvalid0",   bus.rvalid0,   (rv_at == cyc && rv_who == 0));
      checkOutput("rvalid1",   bus.rvalid1,   (rv_at == cyc && rv_who == 1));
      checkOutput("mem_wr_en", bus.mem_wr_en, (wr_at == cyc));
      checkOutput("busy",      bus.busy,      (cyc <= busy_last));
      checkOutput("mem_addr",  bus.mem_addr,  e_addr);
      checkOutput("mem_wdata", bus.mem_wdata, e_wdata);
      checkOutput("rdata",     bus.rdata,     e_rdata);
    end
  end

  task automatic applyStimulus(input int who, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    if (who == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // Returns #1 after the edge on which gnt rose, with the number of edges waited.
  task automatic waitGnt(input int who, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      cycles++;
      if ((who == 0 && bus.gnt0) || (who == 1 && bus.gnt1)) seen = 1'b1;
    end
    if (!seen) checkOutput($sformatf("gnt%0d_timeout", who), 32'd0, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int          cyc_wait;
    int          g;
    int          seq [8];
    int          addrs [5];
    addrs = '{0, 4, 8, 12, 0};

    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;
    idleCycles(2);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_gnt0", bus.gnt0, 0);
    rst = 1'b0;
    idleCycles(1);

    $display("[TB] write 0xDEADBEEF to 0x8 from requester 0");
    applyStimulus(0, 1, 1, 32'h8, 32'hDEADBEEF);
    waitGnt(0, cyc_wait);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wr_gnt0", bus.gnt0, 1);
    checkOutput("wr_mem_wr_en", bus.mem_wr_en, 1);
    checkOutput("wr_mem_addr", bus.mem_addr, 32'h8);
    checkOutput("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    idleCycles(1);
    checkOutput("wr_en_one_cycle", bus.mem_wr_en, 0);
    checkOutput("wr_gnt0_one_cycle", bus.gnt0, 0);
    checkOutput("wr_back_idle", bus.busy, 0);

    $display("[TB] read 0x8 from requester 1");
    applyStimulus(1, 1, 0, 32'h8, 0);
    waitGnt(1, cyc_wait);
    applyStimulus(1, 0, 0, 0, 0);
    idleCycles(1);
    checkOutput("rd_rvalid1_early", bus.rvalid1, 0);
    idleCycles(1);
    checkOutput("rd_rvalid1", bus.rvalid1, 1);
    checkOutput("rd_rdata", bus.rdata, 32'hDEADBEEF);
    checkOutput("rd_rvalid0", bus.rvalid0, 0);
    idleCycles(2);

    $display("[TB] round-robin with both requesters busy");
    rst = 1'b1; idleCycles(1); rst = 1'b0;
    applyStimulus(0, 1, 1, 32'h100, 32'hA000_0000);
    applyStimulus(1, 1, 1, 32'h200, 32'hB000_0000);
    g = 0;
    for (int c = 0; c < 60 && g < 8; c++) begin
      @(posedge clk); #1;
      if (bus.gnt0 && g < 8) begin
        seq[g] = 0; g++;
        applyStimulus(0, 1, 1, 32'h100 + 4 * g, 32'hA000_0000 + g);
      end
      if (bus.gnt1 && g < 8) begin
        seq[g] = 1; g++;
        applyStimulus(1, 1, 1, 32'h200 + 4 * g, 32'hB000_0000 + g);
      end
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rr_count", g, 8);
    for (int i = 0; i < 8 && i < g; i++)
      checkOutput($sformatf("rr_grant%0d", i), seq[i], i % 2);
    idleCycles(3);

    $display("[TB] write address sequence 0,4,8,12,0");
    applyStimulus(0, 1, 1, addrs[0], 32'h50);
    for (int i = 0; i < 5; i++) begin
      waitGnt(0, cyc_wait);
      checkOutput($sformatf("seq_addr%0d", i), bus.mem_addr, addrs[i]);
      checkOutput($sformatf("seq_wr%0d", i), bus.mem_wr_en, 1);
      if (i > 0) checkOutput($sformatf("seq_spacing%0d", i), cyc_wait, 2);
      if (i < 4) applyStimulus(0, 1, 1, addrs[i + 1], 32'h50 + i + 1);
      else       applyStimulus(0, 0, 0, 0, 0);
    end
    idleCycles(3);

    $display("[TB] reset during the issue cycle of a read");
    applyStimulus(0, 1, 0, 32'h4, 0);
    waitGnt(0, cyc_wait);
    #1 rst = 1'b1;
    #1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_mid_wr_en", bus.mem_wr_en, 0);
    checkOutput("rst_mid_rvalid0", bus.rvalid0, 0);
    checkOutput("rst_mid_busy", bus.busy, 0);
    checkOutput("rst_mid_addr", bus.mem_addr, 0);
    idleCycles(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idleCycles(1);
      checkOutput($sformatf("rst_no_rvalid%0d", i), bus.rvalid0, 0);
    end

    $display("[TB] misaligned request to 0x6");
    applyStimulus(0, 1, 1, 32'h6, 32'h1234_5678);
    waitGnt(0, cyc_wait);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mis_gnt0", bus.gnt0, 1);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    checkOutput("mis_err0", bus.err0, 1);
    checkOutput("mis_wr_en", bus.mem_wr_en, 0);
    checkOutput("mis_busy", bus.busy, 0);
`else
    checkOutput("mis_err0", bus.err0, 0);
    checkOutput("mis_wr_en", bus.mem_wr_en, 1);
    checkOutput("mis_addr", bus.mem_addr, 32'h6);
`endif
    idleCycles(4);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
